// File: rtl/ocram_arb_pkg.sv
// Shared types and default widths for the on-chip RAM port arbiter.
package ocram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_BE_W   = DEF_DATA_W / 8;

  // Requester identity; also used as the read-return tag.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Quiesce handshake states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } state_e;

endpackage

// File: rtl/ocram_rr_pick.sv
// Two-way chooser: round-robin on conflict, or fixed priority to port B when prio is set.
module ocram_rr_pick
  import ocram_arb_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_e rr_last,
  input  logic  prio,
  output logic  grant_a,
  output logic  grant_b
);

  // A lone requester always wins; on conflict the port that did not win last time goes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      if (prio || (rr_last == PORT_A)) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

endmodule

// File: rtl/ocram_port_arbiter.sv
// Shares one single-port RAM between a read-only port A and a read/write port B.
// One access per cycle, reads tagged for return, reset_req quiesce handshake.
module ocram_port_arbiter
  import ocram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned BE_W       = DEF_BE_W,
  parameter bit          B_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  output logic              quiesced,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  input  logic [BE_W-1:0]   b_byteenable,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  state_e state_q, state_d;
  port_e  rr_last_q, rr_last_d;
  port_e  rd_tag_q, rd_tag_d;
  logic   rd_pend_q, rd_pend_d;

  logic grant_en;
  logic req_a, req_b;
  logic grant_a, grant_b;
  logic b_rd_grant;

  // Requests are only eligible while running and out of reset.
  always_comb begin
    grant_en = ~reset & (state_q == RUN);
    req_a    = a_read & grant_en;
    req_b    = (b_read | b_write) & grant_en;
  end

  ocram_rr_pick u_pick (
    .req_a   (req_a),
    .req_b   (req_b),
    .rr_last (rr_last_q),
    .prio    (B_PRIORITY),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  // Next-state for round-robin pointer, read tracking and quiesce FSM.
  always_comb begin
    rr_last_d  = rr_last_q;
    rd_tag_d   = rd_tag_q;
    state_d    = state_q;
    // b_read with b_write is treated as a write, so it returns nothing.
    b_rd_grant = grant_b & ~b_write;
    rd_pend_d  = grant_a | b_rd_grant;

    if (req_a && req_b) begin
      rr_last_d = grant_a ? PORT_A : PORT_B;
    end

    if (grant_a) begin
      rd_tag_d = PORT_A;
    end else if (b_rd_grant) begin
      rd_tag_d = PORT_B;
    end

    unique case (state_q)
      RUN: begin
        if (reset_req) state_d = DRAIN;
      end
      // No grants here, so the in-flight read always retires in this cycle.
      DRAIN: begin
        if (!rd_pend_d) state_d = reset_req ? HELD : RUN;
      end
      HELD: begin
        if (!reset_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State registers; reset drops any pending read without replay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      rr_last_q <= PORT_B;
      rd_tag_q  <= PORT_A;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      rd_tag_q  <= rd_tag_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Port handshakes, read return and RAM-side mux.
  always_comb begin
    a_waitrequest   = ~grant_a;
    b_waitrequest   = ~grant_b;
    a_readdatavalid = rd_pend_q & (rd_tag_q == PORT_A);
    b_readdatavalid = rd_pend_q & (rd_tag_q == PORT_B);
    a_readdata      = mem_readdata;
    b_readdata      = mem_readdata;

    mem_chipselect  = grant_a | grant_b;
    mem_write       = grant_b & b_write;
    mem_address     = grant_b ? b_address : a_address;
    mem_writedata   = b_writedata;
    mem_byteenable  = (grant_b && b_write) ? b_byteenable : {BE_W{1'b1}};
    mem_clken       = (state_q != HELD);
    quiesced        = ~reset & ~mem_chipselect & ~rd_pend_q;
  end

  // Simultaneous read and write on port B is a master bug.
  a_b_rw_exclusive : assert property (@(posedge clk) disable iff (reset) !(b_read && b_write));

endmodule
